// File: rtl/shift_left_seq.sv
// Lane-granular left shifter: shifts one LANE_W lane per cycle, fill enters at lane 0.
// Define SHIFT_LEFT_SEQ_ONESHOT_EN to do the whole barrel shift in the capture cycle.

`ifdef SHIFT_LEFT_SEQ_ONESHOT_EN
module shift_left_seq_lane #(
  parameter int          LANE_W    = 5,
  parameter int          SHIFT_W   = 3,
  parameter int unsigned MAX_SHIFT = 4
) (
  input  logic [MAX_SHIFT:0][LANE_W-1:0] cand,
  input  logic [SHIFT_W-1:0]             shift,
  output logic [LANE_W-1:0]              lane
);
  // cand[s] is what this lane becomes for a shift of s; illegal shifts never reach here
  always_comb begin
    lane = cand[0];
    for (int unsigned s = 1; s <= MAX_SHIFT; s++)
      if (32'(shift) == s) lane = cand[s];
  end
endmodule
`endif

module shift_left_seq #(
  parameter int          LANE_W    = 5,
  parameter int          LANES     = 10,
  parameter int          SHIFT_W   = 3,
  parameter int unsigned MAX_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W*LANES-1:0]   in_data,
  input  logic [SHIFT_W-1:0]        in_shift,
  input  logic [LANE_W-1:0]         in_fill,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   out_data,
  output logic                      out_err,
  output logic                      busy
);
  localparam int DATA_W = LANE_W*LANES;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_q;
  logic [LANE_W-1:0]   fill_q;
  logic [SHIFT_W-1:0]  count;
  logic                shift_err, shift_zero;

  assign shift_err  = 32'(in_shift) > MAX_SHIFT;
  assign shift_zero = (in_shift == '0);
  assign out_data   = data_q;

`ifdef SHIFT_LEFT_SEQ_ONESHOT_EN
  logic [DATA_W-1:0] shifted;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [MAX_SHIFT:0][LANE_W-1:0] cand;
    for (genvar s = 0; s <= MAX_SHIFT; s++) begin : g_cand
      if (s <= k) begin : g_src
        assign cand[s] = in_data[(k-s)*LANE_W +: LANE_W];
      end else begin : g_fill
        assign cand[s] = in_fill;
      end
    end
    shift_left_seq_lane #(.LANE_W(LANE_W), .SHIFT_W(SHIFT_W), .MAX_SHIFT(MAX_SHIFT)) u_lane (
      .cand  (cand),
      .shift (in_shift),
      .lane  (shifted[k*LANE_W +: LANE_W])
    );
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
      data_q    <= '0;
      fill_q    <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_q   <= in_data;
          fill_q   <= in_fill;
          count    <= in_shift;
          out_err  <= shift_err;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          // errors pass the word through untouched
          if (shift_err || shift_zero) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
`ifdef SHIFT_LEFT_SEQ_ONESHOT_EN
            data_q    <= shifted;
            state     <= DONE;
            out_valid <= 1'b1;
`else
            state     <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          data_q <= {data_q[DATA_W-LANE_W-1:0], fill_q};
          count  <= count - SHIFT_W'(1);
          if (count == SHIFT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          // no same-cycle turnaround: the next request is taken from IDLE
          state     <= IDLE;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: expected results queued at request, checked on output.
module tb_shift_left_seq;
  localparam int LANE_W = 5, LANES = 10, SHIFT_W = 3, MAX_SHIFT = 4;
  localparam int DATA_W = LANE_W*LANES;

  logic              clk = 1'b0, rst = 1'b1;
  logic              in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0] in_data = '0, out_data;
  logic [SHIFT_W-1:0] in_shift = '0;
  logic [LANE_W-1:0] in_fill = '0;
  logic              out_valid, out_ready = 1'b1, out_err, busy;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks = 0, failures = 0, cyc = 0, stall_cnt = 0;
  logic fresh = 1'b1;
  logic [DATA_W-1:0] held_d;
  logic held_e;
  logic [DATA_W-1:0] base;

  shift_left_seq #(.LANE_W(LANE_W), .LANES(LANES), .SHIFT_W(SHIFT_W), .MAX_SHIFT(MAX_SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_fill(in_fill), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [DATA_W-1:0] d, input int s, input logic [LANE_W-1:0] f);
    exp_t e;
    e.data = d;
    e.err  = (s > MAX_SHIFT);
    e.cyc  = 0;
    if (!e.err)
      for (int k = 0; k < LANES; k++) begin
        if (k >= s) e.data[k*LANE_W +: LANE_W] = d[(k-s)*LANE_W +: LANE_W];
        else        e.data[k*LANE_W +: LANE_W] = f;
      end
    return e;
  endfunction

  // Output monitor: first valid cycle checks latency/data/err, stall cycles check hold.
  always @(negedge clk) begin
    if (rst) begin
      fresh     = 1'b1;
      out_ready = 1'b1;
    end else if (out_valid) begin
      if (fresh) begin
        if (sb.size() == 0) chk("unexpected_result", 64'(out_data), 64'(1'bx));
        else begin
          cur = sb.pop_front();
          chk("latency", 64'(cyc), 64'(cur.cyc));
          chk("data", 64'(out_data), 64'(cur.data));
          chk("err", 64'(out_err), 64'(cur.err));
        end
        held_d = out_data;
        held_e = out_err;
        fresh  = 1'b0;
      end else begin
        chk("hold_data", 64'(out_data), 64'(held_d));
        chk("hold_err", 64'(out_err), 64'(held_e));
      end
      chk("in_ready_done", 64'(in_ready), 64'(0));
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
        fresh     = 1'b1;
      end
    end else if (!fresh) begin
      chk("valid_dropped", 64'(0), 64'(1));
      fresh = 1'b1;
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input int s, input logic [LANE_W-1:0] f,
                      input bit keep, input bit track);
    int n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = SHIFT_W'(s);
    in_fill  = f;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(0), 64'(1));
    else if (track) begin
      e = model(d, s, f);
`ifdef SHIFT_LEFT_SEQ_ONESHOT_EN
      e.cyc = cyc + 1;
`else
      e.cyc = cyc + 1 + ((s == 0 || s > MAX_SHIFT) ? 0 : s);
`endif
      sb.push_back(e);
    end
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < LANES; k++) base[k*LANE_W +: LANE_W] = LANE_W'(k);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_err", 64'(out_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    send(base, 2, 5'h1F, 0, 1); drain();
    send(base, 0, 5'h00, 0, 1); drain();
    stall_cnt = 3;
    send(base, 4, 5'h0A, 0, 1); drain();
    send(base, 5, 5'h11, 0, 1); drain();
    send(base, 7, 5'h12, 0, 1); drain();
    send(base, 3, 5'h07, 0, 1); drain();

    // reset mid-request: nothing may come out for it
    send(base, 4, 5'h0A, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_out_data", 64'(out_data), 64'(0));
    repeat (6) @(negedge clk);
    send(base, 1, 5'h15, 0, 1); drain();

    // back-to-back with in_valid held high
    for (int i = 0; i < 6; i++)
      send({$urandom, $urandom}, i + 1, LANE_W'($urandom), 1, 1);
    in_valid = 1'b0;
    drain();

    // random requests with random consumer stalls
    for (int i = 0; i < 10; i++) begin
      stall_cnt = $urandom_range(0, 3);
      send({$urandom, $urandom}, $urandom_range(0, 7), LANE_W'($urandom), 0, 1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
